// File: rtl/tim_multi_ch.sv
// tim_multi_ch: multi-channel APB timer.
// Each channel is a prescaled down-counter that can run periodic or one-shot.
// On expiry a channel sets a sticky flag, drives a maskable level interrupt and
// emits a one-cycle trigger to the ETB. Channels can also be started and stopped
// by ETB pulses.
module tim_multi_ch #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  input  logic [NUM_CH-1:0] etb_trig_en_on,
  input  logic [NUM_CH-1:0] etb_trig_en_off,
  output logic [NUM_CH-1:0] intr,
  output logic [NUM_CH-1:0] etb_trig
);

  logic wr_en;
  logic rd_en;

  logic [NUM_CH-1:0]       en_vec;
  logic [NUM_CH-1:0]       mode_vec;
  logic [NUM_CH-1:0]       imask_vec;
  logic [NUM_CH-1:0]       flag_vec;
  logic [NUM_CH-1:0]       trig_vec;
  logic [NUM_CH*CNT_W-1:0] load_flat;
  logic [NUM_CH*CNT_W-1:0] cnt_flat;
  logic [NUM_CH*PSC_W-1:0] psc_flat;

  // Depending on CNT_W and PSC_W some write-data bits have no destination.
  logic unused_pwdata;

  assign wr_en = psel & penable & pwrite;
  assign rd_en = psel & ~pwrite;
  assign unused_pwdata = ^pwdata;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] load;
    logic [CNT_W-1:0] cnt;
    logic [PSC_W-1:0] psc_set;
    logic [PSC_W-1:0] psc_cnt;
    logic             en;
    logic             mode;
    logic             imask;
    logic             flag;
    logic             trig;

    logic ch_sel;
    logic wr_load;
    logic wr_ctrl;
    logic wr_stat;
    logic tick;
    logic expiry;
    logic cmd_valid;
    logic cmd_en;
    logic en_next;

    // Decode this channel's writes, the prescaler tick, expiry and the
    // resolved enable: etb_off beats etb_on beats an APB CTRL write, and any
    // of them overrides the one-shot self-clear.
    always_comb begin
      ch_sel    = (paddr[7:4] == 4'(i));
      wr_load   = wr_en & ch_sel & (paddr[3:0] == 4'h0);
      wr_ctrl   = wr_en & ch_sel & (paddr[3:0] == 4'h8);
      wr_stat   = wr_en & ch_sel & (paddr[3:0] == 4'hC);
      tick      = en & (psc_cnt == psc_set);
      expiry    = tick & (cnt == '0);
      cmd_valid = etb_trig_en_off[i] | etb_trig_en_on[i] | wr_ctrl;
      if (etb_trig_en_off[i]) begin
        cmd_en = 1'b0;
      end else if (etb_trig_en_on[i]) begin
        cmd_en = 1'b1;
      end else begin
        cmd_en = pwdata[0];
      end
      en_next = cmd_valid ? cmd_en : (en & ~(expiry & mode));
    end

    // Channel registers, prescaler and counter. A 0->1 enable reloads; a
    // disable freezes the counter; a tick decrements or, at zero, reloads
    // (periodic, or one-shot that was re-asserted in the same cycle).
    always_ff @(posedge pclk) begin
      if (!presetn) begin
        load    <= '0;
        cnt     <= '0;
        psc_set <= '0;
        psc_cnt <= '0;
        en      <= 1'b0;
        mode    <= 1'b0;
        imask   <= 1'b0;
        flag    <= 1'b0;
        trig    <= 1'b0;
      end else begin
        if (wr_load) begin
          load <= pwdata[CNT_W-1:0];
        end
        if (wr_ctrl) begin
          mode    <= pwdata[1];
          imask   <= pwdata[2];
          psc_set <= pwdata[8 +: PSC_W];
        end
        en   <= en_next;
        trig <= expiry;
        if (expiry) begin
          flag <= 1'b1;
        end else if (wr_stat && pwdata[0]) begin
          flag <= 1'b0;
        end
        if (en_next && !en) begin
          cnt     <= load;
          psc_cnt <= '0;
        end else if (!en_next) begin
          psc_cnt <= '0;
        end else if (tick) begin
          psc_cnt <= '0;
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt <= load;
          end
        end else begin
          psc_cnt <= psc_cnt + PSC_W'(1);
        end
      end
    end

    assign en_vec[i]                    = en;
    assign mode_vec[i]                  = mode;
    assign imask_vec[i]                 = imask;
    assign flag_vec[i]                  = flag;
    assign trig_vec[i]                  = trig;
    assign load_flat[i*CNT_W +: CNT_W]  = load;
    assign cnt_flat[i*CNT_W +: CNT_W]   = cnt;
    assign psc_flat[i*PSC_W +: PSC_W]   = psc_set;
  end

  assign etb_trig = trig_vec;
  assign intr     = presetn ? (flag_vec & ~imask_vec) : '0;

  // Combinational read mux; anything unmapped or out of channel range reads 0.
  always_comb begin
    prdata = '0;
    if (rd_en && presetn) begin
      if (paddr == 8'h80) begin
        prdata[NUM_CH-1:0] = intr;
      end else if (paddr == 8'h84) begin
        prdata[NUM_CH-1:0] = flag_vec;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (paddr[7:4] == 4'(c)) begin
            case (paddr[3:0])
              4'h0: prdata[CNT_W-1:0] = load_flat[c*CNT_W +: CNT_W];
              4'h4: prdata[CNT_W-1:0] = cnt_flat[c*CNT_W +: CNT_W];
              4'h8: begin
                prdata[0]          = en_vec[c];
                prdata[1]          = mode_vec[c];
                prdata[2]          = imask_vec[c];
                prdata[8 +: PSC_W] = psc_flat[c*PSC_W +: PSC_W];
              end
              4'hC: prdata[0] = flag_vec[c];
              default: prdata = '0;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tim_multi_ch.sv
// tb_tim_multi_ch: scoreboard bench for the multi-channel timer, covering a
// default four-channel build and a narrow two-channel, 8-bit build.
module tb_tim_multi_ch;

  localparam int NCH = 4;

  logic            pclk = 1'b0;
  logic            presetn;
  logic            psel;
  logic            psel2;
  logic            penable;
  logic            pwrite;
  logic [7:0]      paddr;
  logic [31:0]     pwdata;
  logic [31:0]     prdata;
  logic [31:0]     prdata2;
  logic [NCH-1:0]  etb_on;
  logic [NCH-1:0]  etb_off;
  logic [NCH-1:0]  intr;
  logic [NCH-1:0]  etb_trig;
  logic [1:0]      intr2;
  logic [1:0]      trig2;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] want;

  // Free-running bus/timer clock.
  always #5 pclk = ~pclk;

  tim_multi_ch #(.NUM_CH(NCH), .CNT_W(32), .PSC_W(8)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .etb_trig_en_on(etb_on), .etb_trig_en_off(etb_off),
    .intr(intr), .etb_trig(etb_trig)
  );

  tim_multi_ch #(.NUM_CH(2), .CNT_W(8), .PSC_W(8)) dut2 (
    .pclk(pclk), .presetn(presetn), .psel(psel2), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata2),
    .etb_trig_en_on(2'b00), .etb_trig_en_off(2'b00),
    .intr(intr2), .etb_trig(trig2)
  );

  // Two-phase APB write; commits at the second rising edge. 'off' is driven on
  // etb_trig_en_off during the commit cycle only.
  task automatic apb_write(input logic tgt, input logic [7:0] a,
                           input logic [31:0] d, input logic [NCH-1:0] off);
    if (tgt) psel2 = 1'b1; else psel = 1'b1;
    pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1; etb_off = off;
    @(negedge pclk);
    psel = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0; etb_off = '0;
  endtask

  // Zero-cycle read taken in the low phase of the clock.
  task automatic apb_read(input logic tgt, input logic [7:0] a, output logic [31:0] d);
    if (tgt) psel2 = 1'b1; else psel = 1'b1;
    pwrite = 1'b0; penable = 1'b1; paddr = a;
    #1;
    d = tgt ? prdata2 : prdata;
    psel = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    psel = 0; psel2 = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    etb_on = '0; etb_off = '0; presetn = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    apb_write(0, 8'h00, 32'd5, '0);
    apb_write(0, 8'h08, 32'h1, '0);
    @(negedge pclk);
    exp_q.push_back(32'd4); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    apb_read(0, 8'h04, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL reset_precount: got %h want %h", got, want); end
    presetn = 1'b0;
    apb_read(0, 8'h04, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL reset_prdata_low: got %h want %h", got, want); end
    @(negedge pclk);
    presetn = 1'b1;
    apb_read(0, 8'h04, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL reset_cur: got %h want %h", got, want); end
    apb_read(0, 8'h08, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL reset_ctrl: got %h want %h", got, want); end
    apb_read(0, 8'h00, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL reset_load: got %h want %h", got, want); end
    want = exp_q.pop_front(); tests++;
    if (32'(intr) !== want) begin fails++; $display("[TB] FAIL reset_intr: got %h want %h", intr, want); end
    want = exp_q.pop_front(); tests++;
    if (32'(etb_trig) !== want) begin fails++; $display("[TB] FAIL reset_trig: got %h want %h", etb_trig, want); end
  endtask

  task automatic test_periodic();
    apb_write(0, 8'h00, 32'd3, '0);
    apb_write(0, 8'h08, 32'h1, '0);
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(32'(3 - (k % 4)));
      exp_q.push_back((k > 0 && (k % 4) == 0) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 9; k++) begin
      apb_read(0, 8'h04, got); want = exp_q.pop_front(); tests++;
      if (got !== want) begin fails++; $display("[TB] FAIL periodic_cur[%0d]: got %h want %h", k, got, want); end
      want = exp_q.pop_front(); tests++;
      if (32'(etb_trig[0]) !== want) begin fails++; $display("[TB] FAIL periodic_trig[%0d]: got %h want %h", k, etb_trig[0], want); end
      @(negedge pclk);
    end
    exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    apb_read(0, 8'h84, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL periodic_rawstat: got %h want %h", got, want); end
    want = exp_q.pop_front(); tests++;
    if (32'(intr) !== want) begin fails++; $display("[TB] FAIL periodic_intr: got %h want %h", intr, want); end
    apb_write(0, 8'h08, 32'h0, '0);
    apb_write(0, 8'h0C, 32'h1, '0);
    apb_read(0, 8'h84, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL periodic_w1c: got %h want %h", got, want); end
  endtask

  task automatic test_oneshot();
    apb_write(0, 8'h10, 32'd2, '0);
    apb_write(0, 8'h18, 32'h103, '0);
    for (int k = 0; k < 11; k++) begin
      exp_q.push_back(k < 2 ? 32'd2 : (k < 4 ? 32'd1 : 32'd0));
      exp_q.push_back(k < 6 ? 32'd1 : 32'd0);
      exp_q.push_back(k == 6 ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 11; k++) begin
      apb_read(0, 8'h14, got); want = exp_q.pop_front(); tests++;
      if (got !== want) begin fails++; $display("[TB] FAIL oneshot_cur[%0d]: got %h want %h", k, got, want); end
      apb_read(0, 8'h18, got); got = got & 32'h1; want = exp_q.pop_front(); tests++;
      if (got !== want) begin fails++; $display("[TB] FAIL oneshot_en[%0d]: got %h want %h", k, got, want); end
      want = exp_q.pop_front(); tests++;
      if (32'(etb_trig[1]) !== want) begin fails++; $display("[TB] FAIL oneshot_trig[%0d]: got %h want %h", k, etb_trig[1], want); end
      @(negedge pclk);
    end
    exp_q.push_back(32'h2); exp_q.push_back(32'h2); exp_q.push_back(32'h102);
    apb_read(0, 8'h84, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL oneshot_rawstat: got %h want %h", got, want); end
    want = exp_q.pop_front(); tests++;
    if (32'(intr) !== want) begin fails++; $display("[TB] FAIL oneshot_intr: got %h want %h", intr, want); end
    apb_read(0, 8'h18, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL oneshot_ctrl: got %h want %h", got, want); end
    apb_write(0, 8'h1C, 32'h1, '0);
  endtask

  task automatic test_imask();
    apb_write(0, 8'h30, 32'd1, '0);
    apb_write(0, 8'h38, 32'h7, '0);
    exp_q.push_back(32'h1); exp_q.push_back(32'h8); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    apb_write(0, 8'h3C, 32'h1, '0);
    want = exp_q.pop_front(); tests++;
    if (32'(etb_trig[3]) !== want) begin fails++; $display("[TB] FAIL imask_trig: got %h want %h", etb_trig[3], want); end
    apb_read(0, 8'h84, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL imask_rawstat_setwins: got %h want %h", got, want); end
    apb_read(0, 8'h80, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL imask_intstat: got %h want %h", got, want); end
    want = exp_q.pop_front(); tests++;
    if (32'(intr) !== want) begin fails++; $display("[TB] FAIL imask_intr: got %h want %h", intr, want); end
    apb_write(0, 8'h3C, 32'h1, '0);
    apb_read(0, 8'h84, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL imask_w1c: got %h want %h", got, want); end
  endtask

  task automatic test_etb();
    apb_write(0, 8'h20, 32'd1, '0);
    apb_write(0, 8'h28, 32'h100, '0);
    exp_q.push_back(32'h1); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'd0); exp_q.push_back(32'h0);
    etb_on = 4'b0100;
    @(negedge pclk);
    etb_on = '0;
    apb_read(0, 8'h28, got); got = got & 32'h1; want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL etb_on_en: got %h want %h", got, want); end
    apb_read(0, 8'h24, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL etb_on_cur: got %h want %h", got, want); end
    repeat (2) @(negedge pclk);
    apb_read(0, 8'h24, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL etb_counting: got %h want %h", got, want); end
    etb_on = 4'b0100;
    @(negedge pclk);
    etb_on = '0;
    apb_read(0, 8'h24, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL etb_on_noreload: got %h want %h", got, want); end
    etb_off = 4'b0100;
    @(negedge pclk);
    etb_off = '0;
    apb_read(0, 8'h28, got); got = got & 32'h1; want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL etb_off_en: got %h want %h", got, want); end
    etb_on = 4'b0100; etb_off = 4'b0100;
    @(negedge pclk);
    etb_on = '0; etb_off = '0;
    apb_read(0, 8'h28, got); got = got & 32'h1; want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL etb_on_off_en: got %h want %h", got, want); end
    apb_read(0, 8'h24, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL etb_on_off_cur: got %h want %h", got, want); end
    apb_write(0, 8'h28, 32'h101, 4'b0100);
    apb_read(0, 8'h28, got); got = got & 32'h1; want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL etb_off_vs_apb: got %h want %h", got, want); end
    apb_write(0, 8'h2C, 32'h1, '0);
  endtask

  task automatic test_oneshot_restart();
    apb_write(0, 8'h10, 32'd2, '0);
    apb_write(0, 8'h18, 32'h3, '0);
    exp_q.push_back(32'h1); exp_q.push_back(32'd2); exp_q.push_back(32'h1);
    exp_q.push_back(32'd1);
    repeat (2) @(negedge pclk);
    etb_on = 4'b0010;
    @(negedge pclk);
    etb_on = '0;
    apb_read(0, 8'h18, got); got = got & 32'h1; want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL restart_en: got %h want %h", got, want); end
    apb_read(0, 8'h14, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL restart_cur: got %h want %h", got, want); end
    want = exp_q.pop_front(); tests++;
    if (32'(etb_trig[1]) !== want) begin fails++; $display("[TB] FAIL restart_trig: got %h want %h", etb_trig[1], want); end
    @(negedge pclk);
    apb_read(0, 8'h14, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL restart_cur_next: got %h want %h", got, want); end
    apb_write(0, 8'h18, 32'h2, '0);
    apb_write(0, 8'h1C, 32'h1, '0);
  endtask

  task automatic test_small_build();
    int k;
    exp_q.push_back(32'h0); exp_q.push_back(32'h12); exp_q.push_back(32'hFF01);
    exp_q.push_back(32'd4864); exp_q.push_back(32'd4864);
    apb_write(1, 8'h20, 32'hAB, '0);
    apb_read(1, 8'h20, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL small_oob_read: got %h want %h", got, want); end
    apb_write(1, 8'h00, 32'hFFFF_FF12, '0);
    apb_read(1, 8'h00, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL small_load_trunc: got %h want %h", got, want); end
    apb_write(1, 8'h08, 32'hFF01, '0);
    apb_read(1, 8'h08, got); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("[TB] FAIL small_ctrl: got %h want %h", got, want); end
    k = 0;
    while (!trig2[0] && k < 6000) begin @(negedge pclk); k++; end
    want = exp_q.pop_front(); tests++;
    if (32'(k) !== want) begin fails++; $display("[TB] FAIL small_first_period: got %0d want %0d", k, want); end
    @(negedge pclk);
    k = 1;
    while (!trig2[0] && k < 6000) begin @(negedge pclk); k++; end
    want = exp_q.pop_front(); tests++;
    if (32'(k) !== want) begin fails++; $display("[TB] FAIL small_period: got %0d want %0d", k, want); end
    apb_write(1, 8'h08, 32'h0, '0);
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_imask();
    test_etb();
    test_oneshot_restart();
    test_small_build();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop if anything stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tim_multi_ch.md
Name: tim_multi_ch

Overview:
Parametrised multi-channel APB timer, the next generation of the team's two-channel timer block. It provides NUM_CH independent down-counters, each with a programmable prescaler, periodic or one-shot mode, a maskable level interrupt, and event-trigger (ETB) start/stop inputs with a one-cycle trigger output. It sits on the peripheral APB bus, and its intr/etb_trig outputs route to the interrupt controller and the ETB.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
CNT_W, 32, counter/load width in bits (8..32)
PSC_W, 8, prescaler width in bits (1..8)

Ports:
pclk  input  1  APB and timer clock
presetn  input  1  synchronous active-low reset, sampled on rising pclk
psel  input  1  APB select
penable  input  1  APB access phase
pwrite  input  1  APB write (1) / read (0)
paddr  input  8  byte address
pwdata  input  32  write data
prdata  output  32  read data
etb_trig_en_on  input  NUM_CH  per-channel start pulse from ETB
etb_trig_en_off  input  NUM_CH  per-channel stop pulse from ETB
intr  output  NUM_CH  per-channel level interrupt
etb_trig  output  NUM_CH  per-channel one-cycle expiry pulse to ETB

Behaviour:
- Reset: presetn=0 at a pclk edge clears all registers, counters, prescaler counters, flags and etb_trig to 0. intr=0 and prdata=0 during reset.
- APB write commits at the edge where psel&penable&pwrite=1. Reads are combinational from paddr while psel&~pwrite, else prdata=0. No wait states.
- Map, channel i at base i*0x10:
  - +0x0 LOAD (RW, [CNT_W-1:0])
  - +0x4 CUR (RO, counter value)
  - +0x8 CTRL (RW): bit0 EN, bit1 MODE (0 periodic, 1 one-shot), bit2 IMASK (1 = masked), bits[8+PSC_W-1:8] PSC
  - +0xC STAT: bit0 FLAG, write 1 to clear
  - 0x80 INTSTAT (RO, intr vector); 0x84 RAWSTAT (RO, FLAG vector)
- Unimplemented bits read 0. Addresses of channels >= NUM_CH and unmapped offsets read 0; writes to them are ignored.
- Enable: when EN goes 0->1 (APB or etb_on), cnt<=LOAD and psc<=0 on that edge.
- Prescale while EN=1: psc increments each cycle. When psc==PSC, psc<=0 and a tick is generated.
- On a tick:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: expiry. FLAG<=1, etb_trig[i]=1 for exactly one cycle (registered, unaffected by IMASK).
  - Periodic expiry: cnt<=LOAD.
  - One-shot expiry: EN<=0, cnt stays 0.
- Period = (LOAD+1)*(PSC+1) cycles. LOAD=0, PSC=0 expires every cycle.
- Disable (EN 1->0): cnt holds its value and psc<=0. A later re-enable reloads from LOAD.
- LOAD written while running takes effect only at the next reload or enable. Writing PSC while running changes the tick compare immediately. If psc>PSC_new, psc continues to its natural wrap.
- intr[i]=FLAG&~IMASK, level, held until cleared.
- Precedence:
  - FLAG set and W1C in the same cycle: set wins.
  - EN: etb_off > etb_on > APB CTRL write. etb_on while already EN=1 has no effect (no reload).
  - Any source asserting EN in a cycle where a one-shot expiry would clear it: EN stays 1 and cnt<=LOAD.
- Channels are fully independent. Counter arithmetic is CNT_W-bit unsigned. There is no underflow past 0.

Test Plan:
- Reset mid-count (LOAD=5, EN=1, presetn=0 for 1 cycle) -> CUR=0, CTRL=0, intr=0, etb_trig=0 on the next cycle.
- Ch0 LOAD=3, PSC=0, periodic, enable -> CUR reads 3,2,1,0,3; etb_trig[0] pulses every 4 cycles; FLAG=1; intr[0]=1.
- Ch1 LOAD=2, PSC=1, one-shot -> expiry 6 cycles after enable; EN reads 0; CUR=0; a single etb_trig[1] pulse; no further pulses.
- IMASK=1 with expiry -> RAWSTAT bit=1, INTSTAT=0, intr=0. A W1C in the expiry cycle leaves FLAG=1; a later W1C clears it.
- etb_trig_en_on[2] pulse with LOAD=1 -> counting starts. Simultaneous on+off -> EN=0. APB EN=1 write together with etb_off -> EN=0.
- NUM_CH=2, CNT_W=8 build -> read of 0x20 returns 0; LOAD write 0xFFFF_FF12 reads back 0x12; PSC=0xFF gives a period of 256*(LOAD+1).
